// File: rtl/hw9_sdivcu.sv
// Sequencer for the 8/4-bit signed sequential divider: one Load, then NBITS
// rounds of Shift -> Sub -> Compare, with a start/ready/done host handshake.
module hw9_sdivcu #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          div_zero,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          Load,
  output logic          Shift,
  output logic          Sub,
  output logic          Compare,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_CMP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:  if (start) state_d = div_zero ? S_ERR : S_LOAD;
      S_LOAD: begin
        count_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = S_CMP;
      S_CMP: begin
        if (count_q == LAST) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    // abort overrides every transition, including the final CMP -> DONE
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // Moore decode; the unused encoding shows the idle/reset output pattern
  always_comb begin
    ready   = 1'b1;
    busy    = 1'b0;
    Load    = 1'b0;
    Shift   = 1'b0;
    Sub     = 1'b0;
    Compare = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_LOAD:  begin ready = 1'b0; busy = 1'b1; Load    = 1'b1; end
      S_SHIFT: begin ready = 1'b0; busy = 1'b1; Shift   = 1'b1; end
      S_SUB:   begin ready = 1'b0; busy = 1'b1; Sub     = 1'b1; end
      S_CMP:   begin ready = 1'b0; busy = 1'b1; Compare = 1'b1; end
      S_DONE:  begin ready = 1'b0; busy = 1'b1; done    = 1'b1; end
      S_ERR:   begin ready = 1'b0; busy = 1'b1; done = 1'b1; err = 1'b1; end
      default: ;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_hw9_sdivcu.sv
// Self-checking bench for hw9_sdivcu: directed vector table, corner sequences
// and random stimulus against a timeline model, for NBITS=4 and NBITS=8.
module tb_hw9_sdivcu;

  logic clk = 1'b0;
  logic reset, start, div_zero, abort;

  logic ready4, busy4, load4, shift4, sub4, cmp4, done4, err4;
  logic ready8, busy8, load8, shift8, sub8, cmp8, done8, err8;
  logic [2:0] cnt4, cnt8;
  logic [7:0] o4, o8;

  assign o4 = {ready4, busy4, load4, shift4, sub4, cmp4, done4, err4};
  assign o8 = {ready8, busy8, load8, shift8, sub8, cmp8, done8, err8};

  hw9_sdivcu #(.NBITS(4), .CW(3)) dut4 (
    .clk(clk), .reset(reset), .start(start), .div_zero(div_zero), .abort(abort),
    .ready(ready4), .busy(busy4), .Load(load4), .Shift(shift4), .Sub(sub4),
    .Compare(cmp4), .done(done4), .err(err4), .count(cnt4)
  );

  hw9_sdivcu #(.NBITS(8), .CW(3)) dut8 (
    .clk(clk), .reset(reset), .start(start), .div_zero(div_zero), .abort(abort),
    .ready(ready8), .busy(busy8), .Load(load8), .Shift(shift8), .Sub(sub8),
    .Compare(cmp8), .done(done8), .err(err8), .count(cnt8)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: md = cycles since start was accepted (0 = idle), me = error completion.
  int md[2];
  bit me[2];
  int mcnt[2];
  int nb[2] = '{4, 8};

  function automatic logic [7:0] mexp(input int i);
    logic [7:0] e;
    int n;
    n = nb[i];
    e = 8'b0;
    if (me[i]) e = 8'b01000011;
    else if (md[i] == 0) e = 8'b10000000;
    else if (md[i] == 1) e = 8'b01100000;
    else if (md[i] <= 1 + 3*n) begin
      case ((md[i] - 2) % 3)
        0: e = 8'b01010000;
        1: e = 8'b01001000;
        default: e = 8'b01000100;
      endcase
    end else e = 8'b01000010;
    return e;
  endfunction

  task automatic mupd(input int i, input bit s, input bit dz, input bit ab);
    int n;
    n = nb[i];
    if ((me[i] || md[i] != 0) && ab) begin
      md[i] = 0; me[i] = 0; mcnt[i] = 0;
    end else if (me[i]) begin
      me[i] = 0;
    end else if (md[i] == 0) begin
      if (s) begin
        if (dz) me[i] = 1;
        else md[i] = 1;
      end
    end else begin
      md[i]++;
      if (md[i] > 2 + 3*n) md[i] = 0;
    end
    if (md[i] >= 2 && md[i] <= 1 + 3*n) mcnt[i] = (md[i] - 2) / 3;
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; me[i] = 0; mcnt[i] = 0;
    end
  endtask

  task automatic step(input bit s, input bit dz, input bit ab);
    start = s; div_zero = dz; abort = ab;
    @(posedge clk);
    for (int i = 0; i < 2; i++) mupd(i, s, dz, ab);
    #1;
    chk("out4", 32'(o4), 32'(mexp(0)));
    chk("cnt4", 32'(cnt4), 32'(mcnt[0]));
    chk("out8", 32'(o8), 32'(mexp(1)));
    chk("cnt8", 32'(cnt8), 32'(mcnt[1]));
    chk("excl4", 32'($countones({load4, shift4, sub4, cmp4}) <= 1), 32'd1);
    chk("excl8", 32'($countones({load8, shift8, sub8, cmp8}) <= 1), 32'd1);
  endtask

  typedef struct {
    bit         s, dz, ab;
    logic [7:0] eo;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit s, input bit dz, input bit ab,
                              input logic [7:0] eo, input int ec);
    vec_t v;
    v.s = s; v.dz = dz; v.ab = ab; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  initial begin
    // expected {ready,busy,Load,Shift,Sub,Compare,done,err} after the edge
    tbl.push_back(mk(1, 0, 0, 8'b01100000, 0)); // LOAD
    tbl.push_back(mk(0, 0, 0, 8'b01010000, 0));
    tbl.push_back(mk(0, 0, 0, 8'b01001000, 0));
    tbl.push_back(mk(0, 0, 0, 8'b01000100, 0));
    tbl.push_back(mk(1, 0, 0, 8'b01010000, 1)); // start while busy: ignored
    tbl.push_back(mk(0, 0, 0, 8'b01001000, 1));
    tbl.push_back(mk(0, 0, 0, 8'b01000100, 1));
    tbl.push_back(mk(0, 0, 0, 8'b01010000, 2));
    tbl.push_back(mk(0, 0, 0, 8'b01001000, 2));
    tbl.push_back(mk(0, 0, 0, 8'b01000100, 2));
    tbl.push_back(mk(0, 0, 0, 8'b01010000, 3));
    tbl.push_back(mk(0, 0, 0, 8'b01001000, 3));
    tbl.push_back(mk(0, 0, 0, 8'b01000100, 3));
    tbl.push_back(mk(0, 0, 0, 8'b01000010, 3)); // DONE at T+14
    tbl.push_back(mk(1, 0, 0, 8'b10000000, 3)); // start in DONE ignored
    tbl.push_back(mk(1, 0, 0, 8'b01100000, 3)); // new Load, count held
    tbl.push_back(mk(0, 0, 1, 8'b10000000, 0)); // abort in LOAD
    tbl.push_back(mk(1, 1, 0, 8'b01000011, 0)); // divide by zero
    tbl.push_back(mk(0, 1, 0, 8'b10000000, 0));
    tbl.push_back(mk(0, 1, 1, 8'b10000000, 0)); // abort/div_zero in IDLE ignored
    tbl.push_back(mk(1, 0, 1, 8'b01100000, 0)); // start beats abort in IDLE
    tbl.push_back(mk(0, 0, 1, 8'b10000000, 0));

    start = 0; div_zero = 0; abort = 0;
    reset = 1;
    mreset();
    @(posedge clk);
    #1;
    chk("reset_out", 32'(o4), 32'h80);
    chk("reset_cnt", 32'(cnt4), 32'd0);
    reset = 0;

    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].dz, tbl[k].ab);
      chk($sformatf("vec%0d_out", k), 32'(o4), 32'(tbl[k].eo));
      chk($sformatf("vec%0d_cnt", k), 32'(cnt4), 32'(tbl[k].ec));
    end

    // abort in round 2 SUB
    step(0, 0, 1);
    step(1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0);
    chk("sub2_sub", 32'(sub4), 32'd1);
    chk("sub2_cnt", 32'(cnt4), 32'd2);
    step(0, 0, 1);
    chk("ab_sub2_ready", 32'(ready4), 32'd1);
    chk("ab_sub2_cnt", 32'(cnt4), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      chk("ab_sub2_nodone", 32'(done4), 32'd0);
    end

    // abort on the final Compare
    step(1, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 0);
    chk("lastcmp_cmp", 32'(cmp4), 32'd1);
    chk("lastcmp_cnt", 32'(cnt4), 32'd3);
    step(0, 0, 1);
    chk("ab_last_done", 32'(done4), 32'd0);
    chk("ab_last_ready", 32'(ready4), 32'd1);
    step(0, 0, 0);
    chk("ab_last_done2", 32'(done4), 32'd0);

    // asynchronous reset during SHIFT, between clock edges
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("pre_rst_shift", 32'(shift4), 32'd1);
    #3 reset = 1;
    #1;
    chk("async_rst_out4", 32'(o4), 32'h80);
    chk("async_rst_out8", 32'(o8), 32'h80);
    chk("async_rst_cnt4", 32'(cnt4), 32'd0);
    mreset();
    #2 reset = 0;
    step(1, 0, 0);
    chk("post_rst_load", 32'(load4), 32'd1);
    for (int k = 0; k < 13; k++) step(0, 0, 0);
    chk("post_rst_done", 32'(done4), 32'd1);
    chk("post_rst_err", 32'(err4), 32'd0);

    // NBITS=8: done 26 cycles after acceptance, count reaches 7
    step(0, 0, 1);
    step(1, 0, 0);
    for (int k = 2; k <= 26; k++) begin
      step(0, 0, 0);
      if (k < 26) chk("n8_nodone", 32'(done8), 32'd0);
    end
    chk("n8_done", 32'(done8), 32'd1);
    chk("n8_cnt", 32'(cnt8), 32'd7);
    step(0, 0, 0);
    chk("n8_ready", 32'(ready8), 32'd1);

    // random traffic against the timeline model
    for (int k = 0; k < 3000; k++)
      step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 16) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
